dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the target end of the core's load/store interface. Accepts one read or write request at a time from the datapath (address, write data, MemRead/MemWrite strobes), inserts a configurable number of wait states, then returns read data with a one-cycle `ready` pulse. Replaces the zero-latency data memory so the core and its stall logic can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one request at a time, LATENCY wait states, one-cycle ready pulse.
// Define DMEM_BYTE_EN for sub-word loads/stores (RISC-V funct3 sizes); otherwise every access is a full word.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemoryAddress,
  input  logic [31:0] WriteData,
  input  logic [2:0]  size,
  output logic [31:0] ReadData,
  output logic        ready,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] idx_r;
  logic [31:0]   wdata_r;
  logic          write_r;
  logic          rej_r;
  logic          req_err_s;
  logic [AW-1:0] cur_idx_s;
  logic [31:0]   cur_wdata_s;
  logic          cur_write_s;
  logic          cur_rej_s;
  logic          enter_resp_s;
  logic [31:0]   word_s;
  logic [31:0]   load_value_s;
  logic [31:0]   store_value_s;

`ifdef DMEM_BYTE_EN
  logic [2:0] size_r, cur_size_s;
  logic [1:0] lane_r, cur_lane_s;

  function automatic logic size_bad(input logic is_write, input logic [2:0] sz, input logic [1:0] lane);
    case (sz)
      3'b000:  size_bad = 1'b0;
      3'b001:  size_bad = lane[0];
      3'b010:  size_bad = (lane != 2'b00);
      3'b100:  size_bad = is_write;
      3'b101:  size_bad = is_write | lane[0];
      default: size_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [2:0] sz, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      3'b000:  load_lane = {{24{b[7]}}, b};
      3'b001:  load_lane = {{16{h[15]}}, h};
      3'b100:  load_lane = {24'd0, b};
      3'b101:  load_lane = {16'd0, h};
      default: load_lane = word;
    endcase
  endfunction

  // Read-modify-write merge: only the addressed byte lanes take the store data.
  function automatic logic [31:0] store_lane(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [2:0] sz, input logic [1:0] lane);
    logic [31:0] mask;
    logic [31:0] data;
    case (sz)
      3'b000: begin
        mask = 32'h0000_00FF << {lane, 3'b000};
        data = {4{wd[7:0]}};
      end
      3'b001: begin
        mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        data = {2{wd[15:0]}};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wd;
      end
    endcase
    store_lane = (old & ~mask) | (data & mask);
  endfunction
`endif

  // Classify the request currently on the inputs.
  always_comb begin
    req_err_s = (MemRead & MemWrite) | ((MemoryAddress[31:2] >> AW) != 30'd0);
`ifdef DMEM_BYTE_EN
    req_err_s = req_err_s | size_bad(MemWrite, size, MemoryAddress[1:0]);
`else
    req_err_s = req_err_s | (MemoryAddress[1:0] != 2'b00);
`endif
  end

  // With LATENCY=0 RESP is entered from IDLE, so the live inputs stand in for the latched request.
  always_comb begin
    if (state_r == IDLE) begin
      cur_idx_s   = MemoryAddress[AW+1:2];
      cur_wdata_s = WriteData;
      cur_write_s = MemWrite;
      cur_rej_s   = req_err_s;
    end else begin
      cur_idx_s   = idx_r;
      cur_wdata_s = wdata_r;
      cur_write_s = write_r;
      cur_rej_s   = rej_r;
    end
`ifdef DMEM_BYTE_EN
    if (state_r == IDLE) begin
      cur_size_s = size;
      cur_lane_s = MemoryAddress[1:0];
    end else begin
      cur_size_s = size_r;
      cur_lane_s = lane_r;
    end
`endif
  end

  // Storage datapath: read word and merged store value for the active request.
  always_comb begin
    word_s = mem_r[cur_idx_s];
`ifdef DMEM_BYTE_EN
    load_value_s  = load_lane(word_s, cur_size_s, cur_lane_s);
    store_value_s = store_lane(word_s, cur_wdata_s, cur_size_s, cur_lane_s);
`else
    load_value_s  = word_s;
    store_value_s = cur_wdata_s;
`endif
  end

  // Next-state and wait-state counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (MemRead | MemWrite) begin
          state_nxt_s = (LATENCY == 0) ? RESP : WAIT;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  assign enter_resp_s = (state_nxt_s == RESP) && (state_r != RESP);

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Latch the request at acceptance; the initiator's held signals are not re-sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r   <= '0;
      wdata_r <= 32'd0;
      write_r <= 1'b0;
      rej_r   <= 1'b0;
`ifdef DMEM_BYTE_EN
      size_r  <= 3'd0;
      lane_r  <= 2'd0;
`endif
    end else if ((state_r == IDLE) && (MemRead | MemWrite)) begin
      idx_r   <= MemoryAddress[AW+1:2];
      wdata_r <= WriteData;
      write_r <= MemWrite;
      rej_r   <= req_err_s;
`ifdef DMEM_BYTE_EN
      size_r  <= size;
      lane_r  <= MemoryAddress[1:0];
`endif
    end
  end

  // Storage array; a write commits on the edge entering RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (enter_resp_s && cur_write_s && !cur_rej_s) begin
      mem_r[cur_idx_s] <= store_value_s;
    end
  end

  // Registered response outputs; ReadData/err only move on the edge entering RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadData <= 32'd0;
      ready    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ready <= (state_nxt_s == RESP);
      busy  <= (state_nxt_s != IDLE);
      if (enter_resp_s) begin
        err      <= cur_rej_s;
        ReadData <= (cur_rej_s || cur_write_s) ? 32'd0 : load_value_s;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 instance for function/timing, LATENCY=0 instance for throughput.
// Follows DMEM_BYTE_EN the same way as the RTL.
module tb_dmem_responder;
  typedef struct {
    string       nm;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  sz;
    logic [31:0] data;
    logic        er;
    logic        chk;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_rd = 1'b0, a_wr = 1'b0;
  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
  logic [2:0]  a_size = 3'b010;
  logic [31:0] a_rdata;
  logic        a_ready, a_err, a_busy;
  logic        b_rd = 1'b0, b_wr = 1'b0;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
  logic [2:0]  b_size = 3'b010;
  logic [31:0] b_rdata;
  logic        b_ready, b_err, b_busy;

  int          checks = 0;
  int          failures = 0;
  req_t        sb[$];
  logic [31:0] bsb[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .MemRead(a_rd), .MemWrite(a_wr), .MemoryAddress(a_addr),
    .WriteData(a_wdata), .size(a_size), .ReadData(a_rdata), .ready(a_ready), .err(a_err), .busy(a_busy)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .MemRead(b_rd), .MemWrite(b_wr), .MemoryAddress(b_addr),
    .WriteData(b_wdata), .size(b_size), .ReadData(b_rdata), .ready(b_ready), .err(b_err), .busy(b_busy)
  );

  // Drives one request into the LATENCY=2 instance and records what came back (no judging here).
  task automatic run_a(input req_t r, output int cyc, output logic [31:0] d, output logic er,
                       output logic bz, output logic idle);
    logic got;
    @(negedge clk);
    a_wr = r.wr; a_rd = r.rd; a_addr = r.addr; a_wdata = r.wd; a_size = r.sz;
    sb.push_back(r);
    cyc = 0; got = 1'b0; bz = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) bz = a_busy;
      if (a_ready === 1'b1) got = 1'b1;
    end
    d = a_rdata; er = a_err;
    a_wr = 1'b0; a_rd = 1'b0;
    if (!got) cyc = 99;
    @(posedge clk); #1;
    idle = (a_ready === 1'b0) && (a_busy === 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_rdata, a_ready, a_err, a_busy} !== 35'd0) begin
      failures++; $display("FAIL reset_a: got %h/%b/%b/%b want 0/0/0/0", a_rdata, a_ready, a_err, a_busy);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({b_rdata, b_ready, b_err, b_busy} !== 35'd0) begin
      failures++; $display("FAIL reset_b: got %h/%b/%b/%b want 0/0/0/0", b_rdata, b_ready, b_err, b_busy);
    end
  endtask

  task automatic test_word;
    req_t l[$]; req_t e; int cyc; logic [31:0] d; logic er, bz, idle;
    l.push_back(req_t'{"lw_fresh", 1'b0, 1'b1, 32'h10, 32'd0, 3'b010, 32'h0, 1'b0, 1'b1});
    l.push_back(req_t'{"sw_10", 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 1'b0});
    l.push_back(req_t'{"lw_10", 1'b0, 1'b1, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b1});
    l.push_back(req_t'{"sw_3fc", 1'b1, 1'b0, 32'h3FC, 32'h0BADF00D, 3'b010, 32'h0, 1'b0, 1'b0});
    l.push_back(req_t'{"lw_3fc", 1'b0, 1'b1, 32'h3FC, 32'd0, 3'b010, 32'h0BADF00D, 1'b0, 1'b1});
    foreach (l[i]) begin
      run_a(l[i], cyc, d, er, bz, idle);
      e = sb.pop_front();
      checks++; if (cyc != 3) begin failures++; $display("FAIL %s latency: got %0d want 3", e.nm, cyc); end
      checks++; if (bz !== 1'b1) begin failures++; $display("FAIL %s busy: got %b want 1", e.nm, bz); end
      checks++; if (er !== e.er) begin failures++; $display("FAIL %s err: got %b want %b", e.nm, er, e.er); end
      if (e.chk) begin
        checks++; if (d !== e.data) begin failures++; $display("FAIL %s data: got %h want %h", e.nm, d, e.data); end
      end
      checks++; if (!idle) begin failures++; $display("FAIL %s pulse: ready/busy got %b/%b want 0/0", e.nm, a_ready, a_busy); end
    end
  endtask

  task automatic test_errors;
    req_t l[$]; req_t e; int cyc; logic [31:0] d; logic er, bz, idle;
    l.push_back(req_t'{"lw_oor", 1'b0, 1'b1, 32'h400, 32'd0, 3'b010, 32'h0, 1'b1, 1'b1});
    l.push_back(req_t'{"both", 1'b1, 1'b1, 32'h10, 32'h11111111, 3'b010, 32'h0, 1'b1, 1'b1});
    l.push_back(req_t'{"sw_oor", 1'b1, 1'b0, 32'h8000_0010, 32'h22222222, 3'b010, 32'h0, 1'b1, 1'b0});
    l.push_back(req_t'{"lw_10_kept", 1'b0, 1'b1, 32'h10, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0, 1'b1});
    foreach (l[i]) begin
      run_a(l[i], cyc, d, er, bz, idle);
      e = sb.pop_front();
      checks++; if (cyc != 3) begin failures++; $display("FAIL %s latency: got %0d want 3", e.nm, cyc); end
      checks++; if (er !== e.er) begin failures++; $display("FAIL %s err: got %b want %b", e.nm, er, e.er); end
      if (e.chk) begin
        checks++; if (d !== e.data) begin failures++; $display("FAIL %s data: got %h want %h", e.nm, d, e.data); end
      end
    end
  endtask

`ifdef DMEM_BYTE_EN
  task automatic test_sizes;
    req_t l[$]; req_t e; int cyc; logic [31:0] d; logic er, bz, idle;
    l.push_back(req_t'{"sw_20", 1'b1, 1'b0, 32'h20, 32'h000080FF, 3'b010, 32'h0, 1'b0, 1'b0});
    l.push_back(req_t'{"lb_20", 1'b0, 1'b1, 32'h20, 32'd0, 3'b000, 32'hFFFFFFFF, 1'b0, 1'b1});
    l.push_back(req_t'{"lbu_20", 1'b0, 1'b1, 32'h20, 32'd0, 3'b100, 32'h000000FF, 1'b0, 1'b1});
    l.push_back(req_t'{"lh_20", 1'b0, 1'b1, 32'h20, 32'd0, 3'b001, 32'hFFFF80FF, 1'b0, 1'b1});
    l.push_back(req_t'{"lhu_20", 1'b0, 1'b1, 32'h20, 32'd0, 3'b101, 32'h000080FF, 1'b0, 1'b1});
    l.push_back(req_t'{"sb_23", 1'b1, 1'b0, 32'h23, 32'h00000012, 3'b000, 32'h0, 1'b0, 1'b0});
    l.push_back(req_t'{"lw_20", 1'b0, 1'b1, 32'h20, 32'd0, 3'b010, 32'h120080FF, 1'b0, 1'b1});
    l.push_back(req_t'{"lh_21", 1'b0, 1'b1, 32'h21, 32'd0, 3'b001, 32'h0, 1'b1, 1'b1});
    l.push_back(req_t'{"lw_22", 1'b0, 1'b1, 32'h22, 32'd0, 3'b010, 32'h0, 1'b1, 1'b1});
    l.push_back(req_t'{"ld_011", 1'b0, 1'b1, 32'h20, 32'd0, 3'b011, 32'h0, 1'b1, 1'b1});
    l.push_back(req_t'{"sbu_bad", 1'b1, 1'b0, 32'h20, 32'h000000AA, 3'b100, 32'h0, 1'b1, 1'b0});
    l.push_back(req_t'{"sh_22", 1'b1, 1'b0, 32'h22, 32'h0000BEEF, 3'b001, 32'h0, 1'b0, 1'b0});
    l.push_back(req_t'{"lw_20b", 1'b0, 1'b1, 32'h20, 32'd0, 3'b010, 32'hBEEF80FF, 1'b0, 1'b1});
    foreach (l[i]) begin
      run_a(l[i], cyc, d, er, bz, idle);
      e = sb.pop_front();
      checks++; if (cyc != 3) begin failures++; $display("FAIL %s latency: got %0d want 3", e.nm, cyc); end
      checks++; if (er !== e.er) begin failures++; $display("FAIL %s err: got %b want %b", e.nm, er, e.er); end
      if (e.chk) begin
        checks++; if (d !== e.data) begin failures++; $display("FAIL %s data: got %h want %h", e.nm, d, e.data); end
      end
    end
  endtask
`else
  task automatic test_align;
    req_t l[$]; req_t e; int cyc; logic [31:0] d; logic er, bz, idle;
    l.push_back(req_t'{"sw_20", 1'b1, 1'b0, 32'h20, 32'h000080FF, 3'b000, 32'h0, 1'b0, 1'b0});
    l.push_back(req_t'{"lw_20", 1'b0, 1'b1, 32'h20, 32'd0, 3'b000, 32'h000080FF, 1'b0, 1'b1});
    l.push_back(req_t'{"lw_22", 1'b0, 1'b1, 32'h22, 32'd0, 3'b010, 32'h0, 1'b1, 1'b1});
    l.push_back(req_t'{"sw_21", 1'b1, 1'b0, 32'h21, 32'h12345678, 3'b010, 32'h0, 1'b1, 1'b0});
    l.push_back(req_t'{"lw_20b", 1'b0, 1'b1, 32'h20, 32'd0, 3'b101, 32'h000080FF, 1'b0, 1'b1});
    foreach (l[i]) begin
      run_a(l[i], cyc, d, er, bz, idle);
      e = sb.pop_front();
      checks++; if (cyc != 3) begin failures++; $display("FAIL %s latency: got %0d want 3", e.nm, cyc); end
      checks++; if (er !== e.er) begin failures++; $display("FAIL %s err: got %b want %b", e.nm, er, e.er); end
      if (e.chk) begin
        checks++; if (d !== e.data) begin failures++; $display("FAIL %s data: got %h want %h", e.nm, d, e.data); end
      end
    end
  endtask
`endif

  task automatic test_back_to_back;
    logic        exp_rdy;
    logic [31:0] exp_d;
    @(negedge clk);
    b_wr = 1'b1; b_addr = 32'h4; b_wdata = 32'hA5A50001; b_size = 3'b010;
    @(posedge clk); #1;
    checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL b2b_write ready: got %b want 1", b_ready); end
    b_wr = 1'b0;
    @(negedge clk);
    b_rd = 1'b1;
    for (int k = 0; k < 4; k++) bsb.push_back(32'hA5A50001);
    for (int i = 0; i < 8; i++) begin
      exp_rdy = 1'(i % 2);
      @(posedge clk); #1;
      checks++;
      if (b_ready !== exp_rdy) begin failures++; $display("FAIL b2b ready[%0d]: got %b want %b", i, b_ready, exp_rdy); end
      checks++;
      if (b_busy !== exp_rdy) begin failures++; $display("FAIL b2b busy[%0d]: got %b want %b", i, b_busy, exp_rdy); end
      if (b_ready === 1'b1 && bsb.size() > 0) begin
        exp_d = bsb.pop_front();
        checks++;
        if (b_rdata !== exp_d || b_err !== 1'b0) begin
          failures++; $display("FAIL b2b data[%0d]: got %h/%b want %h/0", i, b_rdata, b_err, exp_d);
        end
      end
    end
    b_rd = 1'b0;
    checks++; if (bsb.size() != 0) begin failures++; $display("FAIL b2b count: got %0d left want 0", bsb.size()); end
  endtask

  task automatic test_abort;
    logic seen;
    req_t e; int cyc; logic [31:0] d; logic er, bz, idle;
    @(negedge clk);
    a_wr = 1'b1; a_addr = 32'h8; a_wdata = 32'h55; a_size = 3'b010;
    @(posedge clk); #1;
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL abort busy: got %b want 1", a_busy); end
    rst = 1'b1; a_wr = 1'b0;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_ready !== 1'b0) begin
      failures++; $display("FAIL abort clear: busy/ready got %b/%b want 0/0", a_busy, a_ready);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (a_ready !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL abort ready: got 1 want 0"); end
    run_a(req_t'{"lw_8_after_abort", 1'b0, 1'b1, 32'h8, 32'd0, 3'b010, 32'h0, 1'b0, 1'b1}, cyc, d, er, bz, idle);
    e = sb.pop_front();
    checks++; if (cyc != 3) begin failures++; $display("FAIL %s latency: got %0d want 3", e.nm, cyc); end
    checks++;
    if (d !== e.data || er !== e.er) begin
      failures++; $display("FAIL %s data: got %h/%b want %h/%b", e.nm, d, er, e.data, e.er);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_errors();
`ifdef DMEM_BYTE_EN
    test_sizes();
`else
    test_align();
`endif
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
